fetch_unit: RTL and testbench

//   Instruction fetch stage directly upstream of ctrl_unit. Holds the PC and issues
//   req/ack reads to instruction memory. Presents one instruction at a time, with

---
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel: the fetch stage drives req/addr, memory answers with ack/rdata.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: holds the PC, reads instruction memory with req/ack and presents one
// instruction at a time to the decoder, applying its redirect when the instruction is consumed.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCsrc,
  input  logic [31:0]        target,
  input  logic               stall,
  fetch_unit_if.master       imem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               misalign,
  output logic [31:0]        retired
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_reg, state_next;
  logic        first_reg;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg;
  logic        valid_reg;
  logic        misalign_reg;
  logic [31:0] retired_reg;

  logic        req_int;
  logic        fetch_done;
  logic        consume;
  logic [31:0] target_aligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH: if (fetch_done) state_next = HOLD;
      HOLD:  if (consume)    state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // The cycle right after reset never requests, so a late ack from an abandoned read is dropped.
  always_comb begin
    req_int    = (state_reg == FETCH) && !first_reg;
    fetch_done = req_int && imem.ack;
    consume    = (state_reg == HOLD) && valid_reg && !stall;
  end

  assign target_aligned = target & 32'hFFFF_FFFC;
  assign pc_plus4       = pc_reg + 32'd4;
  assign pc_next        = PCsrc ? target_aligned : pc_plus4;

  always_ff @(posedge clk) begin
    if (rst) begin
      first_reg    <= 1'b1;
      pc_reg       <= RESET_PC & 32'hFFFF_FFFC;
      instr_reg    <= NOP_INSTR;
      valid_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      retired_reg  <= 32'd0;
    end else begin
      first_reg    <= 1'b0;
      misalign_reg <= consume && PCsrc && target[1];
      if (fetch_done) begin
        instr_reg <= imem.rdata;
        valid_reg <= 1'b1;
      end
      if (consume) begin
        pc_reg      <= pc_next;
        instr_reg   <= NOP_INSTR;
        valid_reg   <= 1'b0;
        retired_reg <= retired_reg + 32'd1;
      end
    end
  end

  assign imem.req    = req_int;
  assign imem.addr   = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = valid_reg;
  assign pc          = pc_reg;
  assign misalign    = misalign_reg;
  assign retired     = retired_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table of fetch/consume records plus a reset-mid-wait sequence,
// with a scoreboard of {pc, instr} pushed at each ack and popped when instr_valid rises.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int NVEC = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCsrc = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] target = 32'h0;
  logic [31:0] instr, pc, pc_plus4, retired;
  logic        instr_valid, misalign;

  fetch_unit_if imem();

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .PCsrc(PCsrc), .target(target), .stall(stall),
    .imem(imem), .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .pc_plus4(pc_plus4), .misalign(misalign), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    int          lat;
    int          stall_n;
    logic        stall_pcsrc;
    logic        pcsrc;
    logic [31:0] target;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  vec_t        vecs [NVEC];
  exp_t        sb [$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret;
  int          w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic wait_req();
    w = 0;
    while (imem.req !== 1'b1 && w < 8) begin
      @(negedge clk);
      w++;
    end
    chk1("req_timeout", imem.req, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    //         addr          rdata         lat st sp    pcsrc target        mis
    vecs[0]  = '{32'h0000_0000, 32'h0050_0093, 0, 0, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{32'h0000_0004, 32'h0010_0113, 0, 0, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[2]  = '{32'h0000_0008, 32'h0020_81b3, 0, 0, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[3]  = '{32'h0000_000C, 32'h0031_2023, 3, 5, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[4]  = '{32'h0000_0010, 32'h0300_006f, 0, 0, 1'b0, 1'b1, 32'h0000_0040, 1'b0};
    vecs[5]  = '{32'h0000_0040, 32'h0000_8067, 1, 0, 1'b0, 1'b1, 32'h0000_0047, 1'b1};
    vecs[6]  = '{32'h0000_0044, 32'h00a0_0293, 0, 2, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[7]  = '{32'h0000_0048, 32'hfb5f_f06f, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0};
    vecs[8]  = '{32'hFFFF_FFFC, 32'h00c0_0313, 0, 1, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[9]  = '{32'h0000_0000, 32'h0050_0093, 2, 0, 1'b0, 1'b1, 32'h0000_0021, 1'b0};
    vecs[10] = '{32'h0000_0020, 32'h0000_0463, 0, 0, 1'b0, 1'b0, 32'h0,         1'b0};

    // Reset for two edges with an ack present: the data must be dropped.
    imem.ack   = 1'b1;
    imem.rdata = 32'hBAD0_BAD0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    imem.ack = 1'b0;
    exp_ret  = 32'd0;
    chk1("rst_valid",    instr_valid, 1'b0);
    chk1("rst_req",      imem.req,    1'b0);
    chk1("rst_misalign", misalign,    1'b0);
    chk("rst_instr",     instr,       NOP);
    chk("rst_pc",        pc,          32'h0);
    chk("rst_pc_plus4",  pc_plus4,    32'h4);
    chk("rst_retired",   retired,     32'h0);

    for (int v = 0; v < NVEC; v++) begin
      wait_req();
      chk("req_addr", imem.addr, vecs[v].addr);
      chk1("valid_in_fetch", instr_valid, 1'b0);
      for (int c = 0; c < vecs[v].lat; c++) begin
        imem.ack   = 1'b0;
        imem.rdata = $urandom;
        @(negedge clk);
        chk1("req_held", imem.req, 1'b1);
        chk("addr_held", imem.addr, vecs[v].addr);
      end
      imem.ack   = 1'b1;
      imem.rdata = vecs[v].rdata;
      sb.push_back('{vecs[v].addr, vecs[v].rdata});
      @(negedge clk);
      imem.ack = 1'b0;
      chk1("req_low_hold", imem.req,    1'b0);
      chk1("valid_set",    instr_valid, 1'b1);
      chk1("misalign_low", misalign,    1'b0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty actual=0 required=1");
        e = '{32'h0, 32'h0};
      end else begin
        e = sb.pop_front();
      end
      chk("instr",    instr,    e.instr);
      chk("pc",       pc,       e.pc);
      chk("pc_plus4", pc_plus4, e.pc + 32'd4);
      $display("txn %0d pc=%h instr=%h lat=%0d stall=%0d", v, pc, instr, vecs[v].lat, vecs[v].stall_n);

      // Stalled cycles: redirect request and stray acks must have no effect.
      stall  = 1'b1;
      PCsrc  = vecs[v].stall_pcsrc;
      target = 32'h0000_0080;
      for (int s = 0; s < vecs[v].stall_n; s++) begin
        imem.ack   = 1'b1;
        imem.rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stall_instr",   instr,   e.instr);
        chk("stall_pc",      pc,      e.pc);
        chk("stall_retired", retired, exp_ret);
        chk1("stall_valid",  instr_valid, 1'b1);
        chk1("stall_req",    imem.req,    1'b0);
      end
      imem.ack = 1'b0;
      stall    = 1'b0;
      PCsrc    = vecs[v].pcsrc;
      target   = vecs[v].target;
      @(negedge clk);
      exp_ret = exp_ret + 32'd1;
      PCsrc   = 1'b0;
      target  = 32'h0;
      chk("retired",       retired,  exp_ret);
      chk1("misalign",     misalign, vecs[v].mis);
      chk1("consume_valid", instr_valid, 1'b0);
      chk("consume_instr", instr,    NOP);
    end

    // Reset while a request to 0x8 is waiting, with a late ack right after reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 32'd0;
    for (int k = 0; k < 2; k++) begin
      wait_req();
      chk("seq_addr", imem.addr, 32'(k * 4));
      imem.ack   = 1'b1;
      imem.rdata = 32'h0000_0013;
      @(negedge clk);
      imem.ack = 1'b0;
      chk1("seq_valid", instr_valid, 1'b1);
      @(negedge clk);
    end
    wait_req();
    chk("mid_addr", imem.addr, 32'h8);
    chk("mid_retired", retired, 32'd2);
    imem.ack = 1'b0;
    @(negedge clk);
    chk1("mid_req_held", imem.req, 1'b1);
    rst        = 1'b1;
    imem.ack   = 1'b1;
    imem.rdata = 32'hBADB_AD00;
    @(negedge clk);
    rst = 1'b0;
    chk1("post_rst_req",   imem.req,    1'b0);
    chk1("post_rst_valid", instr_valid, 1'b0);
    chk("post_rst_retired", retired,    32'd0);
    chk("post_rst_pc",      pc,         32'h0);
    @(negedge clk);
    imem.ack = 1'b0;
    chk1("late_ack_valid", instr_valid, 1'b0);
    chk("late_ack_instr",  instr,       NOP);
    chk1("refetch_req",    imem.req,    1'b1);
    chk("refetch_addr",    imem.addr,   32'h0);
    chk("refetch_retired", retired,     32'd0);
    $display("txn reset_mid_wait refetch addr=%h", imem.addr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
